reg_commit_ctrl: RTL and testbench

//  In-order retirement sequencer between the ROB head and the architectural register file (Reg).

---
 rtl/reg_commit_ctrl_pkg.sv | 20 ++
 rtl/reg_commit_ctrl.sv | 121 ++++++++++++
 tb/tb_reg_commit_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_commit_ctrl_pkg.sv
// rtl/reg_commit_ctrl_pkg.sv - shared encodings for the ROB-head retirement sequencer
package reg_commit_ctrl_pkg;

  localparam int ROB_LR_WIDTH = 4;
  localparam int DATA_WIDTH   = 32;

  typedef enum logic [1:0] {
    ROB_KIND_ALU    = 2'd0,
    ROB_KIND_BRANCH = 2'd1,
    ROB_KIND_STORE  = 2'd2,
    ROB_KIND_NOP    = 2'd3
  } rob_kind_e;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } commit_state_e;

endpackage

// File: rtl/reg_commit_ctrl.sv
// rtl/reg_commit_ctrl.sv - in-order retirement of the ROB head into the architectural register file
import reg_commit_ctrl_pkg::*;

module reg_commit_ctrl #(
  parameter int ROB_LR_W  = ROB_LR_WIDTH,
  parameter int XLEN      = DATA_WIDTH,
  parameter int FLUSH_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                rob_head_valid,
  input  logic                rob_head_ready,
  input  logic [1:0]          rob_head_kind,
  input  logic [4:0]          rob_head_rd,
  input  logic [XLEN-1:0]     rob_head_value,
  input  logic [ROB_LR_W-1:0] rob_head_tag,
  input  logic                rob_head_mispred,
  input  logic [XLEN-1:0]     rob_head_target,
  input  logic                reg_busy_commit_rd,
  input  logic [ROB_LR_W-1:0] reg_reorder_commit_rd,
  input  logic                mem_st_done,
  output logic                rob_pop,
  output logic [4:0]          commit_rd,
  output logic                ROB_to_Reg_needchange,
  output logic                ROB_to_Reg_needchange2,
  output logic [XLEN-1:0]     reg_reg_commit_rd_,
  output logic                reg_busy_commit_rd_,
  output logic                mem_st_go,
  output logic                Clear_flag,
  output logic                pc_redirect_valid,
  output logic [XLEN-1:0]     pc_redirect,
  output logic [31:0]         commit_cnt
);

  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  commit_state_e state, state_nxt;
  logic [FW-1:0] flush_cnt;
  logic          fire;
  logic          st_launch;
  logic          flush_start;

  assign fire                = rob_head_valid & rob_head_ready & rdy;
  assign commit_rd           = rob_head_rd;
  assign reg_reg_commit_rd_  = rob_head_value;
  assign reg_busy_commit_rd_ = 1'b0;

  always_comb begin
    state_nxt              = state;
    rob_pop                = 1'b0;
    ROB_to_Reg_needchange  = 1'b0;
    ROB_to_Reg_needchange2 = 1'b0;
    st_launch              = 1'b0;
    flush_start            = 1'b0;
    case (state)
      S_RUN: begin
        if (fire) begin
          case (rob_kind_e'(rob_head_kind))
            ROB_KIND_ALU, ROB_KIND_BRANCH: begin
              rob_pop               = 1'b1;
              ROB_to_Reg_needchange = (rob_head_rd != 5'd0);
              // A younger rename of rd owns the busy bit; only clear it if we are still the producer.
              ROB_to_Reg_needchange2 = (rob_head_rd != 5'd0) & reg_busy_commit_rd &
                                       (reg_reorder_commit_rd == rob_head_tag);
              if (rob_kind_e'(rob_head_kind) == ROB_KIND_BRANCH && rob_head_mispred) begin
                flush_start = 1'b1;
                state_nxt   = S_FLUSH;
              end
            end
            ROB_KIND_STORE: begin
              st_launch = 1'b1;
              state_nxt = S_ST_WAIT;
            end
            default: rob_pop = 1'b1;
          endcase
        end
      end
      S_ST_WAIT: begin
        if (rdy && mem_st_done) begin
          rob_pop   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_FLUSH: begin
        if (rdy && flush_cnt == '0) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= S_RUN;
      flush_cnt         <= '0;
      mem_st_go         <= 1'b0;
      Clear_flag        <= 1'b0;
      pc_redirect_valid <= 1'b0;
      pc_redirect       <= '0;
      commit_cnt        <= '0;
    end else if (rdy) begin
      state             <= state_nxt;
      mem_st_go         <= st_launch;
      pc_redirect_valid <= flush_start;
      commit_cnt        <= commit_cnt + {31'd0, rob_pop};
      if (flush_start) begin
        Clear_flag  <= 1'b1;
        flush_cnt   <= FW'(FLUSH_CYC - 1);
        pc_redirect <= rob_head_target;
      end else if (state == S_FLUSH) begin
        if (flush_cnt == '0) Clear_flag <= 1'b0;
        else                 flush_cnt  <= flush_cnt - 1'b1;
      end
    end else begin
      // Frozen: pulses are withheld and reissue once rdy returns.
      mem_st_go         <= 1'b0;
      pc_redirect_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_commit_ctrl.sv
// tb/tb_reg_commit_ctrl.sv - randomized and directed check of reg_commit_ctrl against a behavioural model
module tb_reg_commit_ctrl;

  localparam int ROB_LR_W  = 4;
  localparam int XLEN      = 32;
  localparam int FLUSH_CYC = 2;

  logic                clk = 1'b0;
  logic                rst_n, rdy, rob_head_valid, rob_head_ready, rob_head_mispred;
  logic [1:0]          rob_head_kind;
  logic [4:0]          rob_head_rd;
  logic [XLEN-1:0]     rob_head_value, rob_head_target;
  logic [ROB_LR_W-1:0] rob_head_tag, reg_reorder_commit_rd;
  logic                reg_busy_commit_rd, mem_st_done;
  logic                rob_pop, nc, nc2, busy_out, mem_st_go, Clear_flag, pc_redirect_valid;
  logic [4:0]          commit_rd;
  logic [XLEN-1:0]     reg_val, pc_redirect;
  logic [31:0]         commit_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_store_wait;
  int          m_flush_left;
  bit          m_go, m_redir_v;
  logic [31:0] m_redir, m_cnt;

  always #5 clk = ~clk;

  reg_commit_ctrl #(.ROB_LR_W(ROB_LR_W), .XLEN(XLEN), .FLUSH_CYC(FLUSH_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .rob_head_valid(rob_head_valid), .rob_head_ready(rob_head_ready),
    .rob_head_kind(rob_head_kind), .rob_head_rd(rob_head_rd),
    .rob_head_value(rob_head_value), .rob_head_tag(rob_head_tag),
    .rob_head_mispred(rob_head_mispred), .rob_head_target(rob_head_target),
    .reg_busy_commit_rd(reg_busy_commit_rd), .reg_reorder_commit_rd(reg_reorder_commit_rd),
    .mem_st_done(mem_st_done), .rob_pop(rob_pop), .commit_rd(commit_rd),
    .ROB_to_Reg_needchange(nc), .ROB_to_Reg_needchange2(nc2),
    .reg_reg_commit_rd_(reg_val), .reg_busy_commit_rd_(busy_out),
    .mem_st_go(mem_st_go), .Clear_flag(Clear_flag),
    .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect),
    .commit_cnt(commit_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit head_fires();
    return rdy && rob_head_valid && rob_head_ready;
  endfunction

  function automatic bit in_run();
    return !m_store_wait && m_flush_left == 0;
  endfunction

  task automatic check_model();
    bit exp_pop, exp_nc, exp_nc2, writes;
    writes  = in_run() && head_fires() && (rob_head_kind == 2'd0 || rob_head_kind == 2'd1);
    exp_nc  = writes && rob_head_rd != 5'd0;
    exp_nc2 = exp_nc && reg_busy_commit_rd && reg_reorder_commit_rd == rob_head_tag;
    if (m_flush_left > 0)  exp_pop = 1'b0;
    else if (m_store_wait) exp_pop = rdy && mem_st_done;
    else                   exp_pop = head_fires() && rob_head_kind != 2'd2;
    chk("rob_pop", rob_pop, exp_pop);
    chk("commit_rd", commit_rd, rob_head_rd);
    chk("needchange", nc, exp_nc);
    chk("needchange2", nc2, exp_nc2);
    chk("reg_value", reg_val, rob_head_value);
    chk("busy_out", busy_out, 0);
    chk("mem_st_go", mem_st_go, m_go);
    chk("Clear_flag", Clear_flag, m_flush_left > 0);
    chk("redirect_valid", pc_redirect_valid, m_redir_v);
    chk("pc_redirect", pc_redirect, m_redir);
    chk("commit_cnt", commit_cnt, m_cnt);
    // advance model to the state after the coming posedge
    if (!rst_n) begin
      m_store_wait = 0; m_flush_left = 0; m_go = 0; m_redir_v = 0; m_redir = 0; m_cnt = 0;
    end else if (!rdy) begin
      m_go = 0; m_redir_v = 0;
    end else begin
      m_go      = in_run() && head_fires() && rob_head_kind == 2'd2;
      m_redir_v = in_run() && head_fires() && rob_head_kind == 2'd1 && rob_head_mispred;
      m_cnt     = m_cnt + 32'(exp_pop);
      if (m_store_wait && mem_st_done) m_store_wait = 0;
      else if (m_go)                   m_store_wait = 1;
      if (m_redir_v) begin
        m_redir = rob_head_target; m_flush_left = FLUSH_CYC;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_model();
    @(negedge clk);
  endtask

  task automatic set_head(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] val,
                          input logic [3:0] tag, input logic mis, input logic [31:0] tgt);
    rob_head_valid = 1; rob_head_ready = 1; rob_head_kind = kind; rob_head_rd = rd;
    rob_head_value = val; rob_head_tag = tag; rob_head_mispred = mis; rob_head_target = tgt;
  endtask

  initial begin
    rst_n = 0; rdy = 1; mem_st_done = 0; reg_busy_commit_rd = 0; reg_reorder_commit_rd = 0;
    set_head(2'd3, 0, 0, 0, 0, 0);
    rob_head_valid = 0;
    m_store_wait = 0; m_flush_left = 0; m_go = 0; m_redir_v = 0; m_redir = 0; m_cnt = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1;
    chk("reset_cnt", commit_cnt, 0);
    chk("reset_clear", Clear_flag, 0);
    chk("reset_go", mem_st_go, 0);
    tick();

    // ALU retire, still the producer of rd
    set_head(2'd0, 5, 32'h1234, 3, 0, 0);
    reg_busy_commit_rd = 1; reg_reorder_commit_rd = 3;
    #1;
    chk("alu_pop", rob_pop, 1); chk("alu_nc", nc, 1); chk("alu_nc2", nc2, 1);
    tick();
    chk("alu_cnt", commit_cnt, 1);
    // younger producer holds busy
    reg_reorder_commit_rd = 7;
    #1;
    chk("young_nc", nc, 1); chk("young_nc2", nc2, 0);
    tick();
    set_head(2'd0, 0, 32'h55, 3, 0, 0);
    reg_reorder_commit_rd = 3;
    #1;
    chk("x0_pop", rob_pop, 1); chk("x0_nc", nc, 0); chk("x0_nc2", nc2, 0);
    tick();

    // store: one launch pulse, no pop until done
    set_head(2'd2, 9, 32'hAA, 4, 0, 0);
    #1; chk("st_launch_pop", rob_pop, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_wait_pop", rob_pop, 0);
      chk("st_go_pulse", mem_st_go, i == 0);
      tick();
    end
    mem_st_done = 1;
    #1; chk("st_done_pop", rob_pop, 1);
    tick();
    mem_st_done = 0;
    rob_head_valid = 0;
    tick();

    // rdy low in ST_WAIT masks mem_st_done
    set_head(2'd2, 9, 32'hAA, 4, 0, 0);
    tick();
    rob_head_valid = 0; rdy = 0; mem_st_done = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("frozen_pop", rob_pop, 0);
      tick();
    end
    rdy = 1;
    #1; chk("thaw_pop", rob_pop, 1);
    tick();
    mem_st_done = 0;

    // mispredicted branch
    set_head(2'd1, 1, 32'h44, 2, 1, 32'h80);
    #1; chk("br_pop", rob_pop, 1);
    tick();
    set_head(2'd0, 6, 32'h9, 5, 0, 0);
    #1;
    chk("fl1_clear", Clear_flag, 1); chk("fl1_redir_v", pc_redirect_valid, 1);
    chk("fl1_redir", pc_redirect, 32'h80); chk("fl1_pop", rob_pop, 0);
    tick();
    #1;
    chk("fl2_clear", Clear_flag, 1); chk("fl2_redir_v", pc_redirect_valid, 0);
    chk("fl2_pop", rob_pop, 0);
    tick();
    #1;
    chk("fl_done_clear", Clear_flag, 0); chk("fl_done_pop", rob_pop, 1);
    tick();

    // reset while flushing
    set_head(2'd1, 1, 32'h44, 2, 1, 32'hC0);
    tick();
    rob_head_valid = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("rst_fl_clear", Clear_flag, 0); chk("rst_fl_cnt", commit_cnt, 0);
    tick();

    for (int i = 0; i < 3000; i++) begin
      rst_n              = ($urandom_range(0, 199) != 0);
      rdy                = ($urandom_range(0, 4) != 0);
      rob_head_valid     = ($urandom_range(0, 5) != 0);
      rob_head_ready     = ($urandom_range(0, 3) != 0);
      rob_head_kind      = 2'($urandom_range(0, 3));
      rob_head_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rob_head_value     = $urandom;
      rob_head_tag       = 4'($urandom_range(0, 3));
      rob_head_mispred   = ($urandom_range(0, 2) == 0);
      rob_head_target    = $urandom;
      reg_busy_commit_rd = $urandom_range(0, 1);
      reg_reorder_commit_rd = 4'($urandom_range(0, 3));
      mem_st_done        = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
